// File: rtl/test_area_prmter_hls_deadlock_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : test_area_prmter_hls_deadlock_detector_if
//  Description : Deadlock report channel between the detector and the
//                simulation/debug logger (valid/ready plus report payload).
//  Revision    : 1.0 - initial release
// ============================================================================
interface test_area_prmter_hls_deadlock_detector_if #(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = 2
);
    logic               report_valid;
    logic               report_ready;
    logic [IDX_W-1:0]   dl_index;
    logic [NUM_MON-1:0] dl_snap_vec;

    // Detector side: offers the report and its payload.
    modport master (
        output report_valid,
        output dl_index,
        output dl_snap_vec,
        input  report_ready
    );

    // Logger side: accepts the report.
    modport slave (
        input  report_valid,
        input  dl_index,
        input  dl_snap_vec,
        output report_ready
    );
endinterface
`default_nettype wire

// File: rtl/test_area_prmter_hls_deadlock_detector.sv
`default_nettype none
// ============================================================================
//  Module      : test_area_prmter_hls_deadlock_detector
//  Description : Confirms a persistent blocked condition across the dataflow
//                monitors, latches a sticky deadlock flag with the lowest
//                blocked monitor index, and hands a one-shot report to the
//                logger over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_area_prmter_hls_deadlock_detector #(
    parameter int NUM_MON        = 4,
    parameter int IDX_W          = 2,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic [NUM_MON-1:0]   dl_in_vec,
    input  wire logic                 clear,
    output logic                      dl_detect_out,
    test_area_prmter_hls_deadlock_detector_if.master rpt
);

    localparam logic [CNT_W-1:0] C_CONFIRM = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_REPORT  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [NUM_MON-1:0] snap_q,     snap_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               detect_q,   detect_d;
    logic [IDX_W-1:0]   index_q,    index_d;
    logic [NUM_MON-1:0] snap_vec_q, snap_vec_d;
    logic               valid_q,    valid_d;

    logic [NUM_MON-1:0] w_common;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Lowest set bit wins; scanning from the top lets lower bits overwrite.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Candidate set can only shrink while confirming.
    assign w_common  = snap_q & dl_in_vec;
    assign w_cnt_inc = cnt_q + C_ONE;

    // Next-state and register updates for the confirm/report/hold sequence.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        detect_d   = detect_q;
        index_d    = index_q;
        snap_vec_d = snap_vec_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE: begin
                if (!clear && (|dl_in_vec)) begin
                    snap_d  = dl_in_vec;
                    cnt_d   = C_ONE;
                    state_d = S_CONFIRM;
                end else begin
                    snap_d  = '0;
                    cnt_d   = '0;
                end
            end

            S_CONFIRM: begin
                if (clear || (w_common == '0)) begin
                    // Transient stall or software abort: start over.
                    snap_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (w_cnt_inc == C_CONFIRM) begin
                    snap_d     = w_common;
                    cnt_d      = '0;
                    detect_d   = 1'b1;
                    snap_vec_d = w_common;
                    index_d    = lowest_set(w_common);
                    valid_d    = 1'b1;
                    state_d    = S_REPORT;
                end else begin
                    snap_d = w_common;
                    cnt_d  = w_cnt_inc;
                end
            end

            S_REPORT: begin
                // clear is deliberately ignored until the logger takes the report.
                if (valid_q && rpt.report_ready) begin
                    valid_d = 1'b0;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                // First deadlock is kept; only clear releases it.
                if (clear) begin
                    snap_d     = '0;
                    cnt_d      = '0;
                    detect_d   = 1'b0;
                    index_d    = '0;
                    snap_vec_d = '0;
                    valid_d    = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            cnt_q      <= '0;
            detect_q   <= 1'b0;
            index_q    <= '0;
            snap_vec_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            detect_q   <= detect_d;
            index_q    <= index_d;
            snap_vec_q <= snap_vec_d;
            valid_q    <= valid_d;
        end
    end

    assign dl_detect_out    = detect_q;
    assign rpt.report_valid = valid_q;
    assign rpt.dl_index     = index_q;
    assign rpt.dl_snap_vec  = snap_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_test_area_prmter_hls_deadlock_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_area_prmter_hls_deadlock_detector
//  Description : Self-checking bench for the deadlock detector; expected
//                reports are queued when blocking stimulus is driven and
//                compared when the logger handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_area_prmter_hls_deadlock_detector;

    localparam int NUM_MON        = 4;
    localparam int IDX_W          = 2;
    localparam int CONFIRM_CYCLES = 16;
    localparam int CNT_W          = 8;

    logic               clk;
    logic               reset;
    logic               clear;
    logic [NUM_MON-1:0] dl_in_vec;
    logic               dl_detect_out;

    test_area_prmter_hls_deadlock_detector_if #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) rpt_if ();

    test_area_prmter_hls_deadlock_detector #(
        .NUM_MON        (NUM_MON),
        .IDX_W          (IDX_W),
        .CONFIRM_CYCLES (CONFIRM_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .dl_in_vec     (dl_in_vec),
        .clear         (clear),
        .dl_detect_out (dl_detect_out),
        .rpt           (rpt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [NUM_MON-1:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_vec(input logic [NUM_MON-1:0] v, input int n);
        dl_in_vec = v;
        repeat (n) step();
    endtask

    task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [NUM_MON-1:0] vec);
        exp_t e;
        e.idx = idx;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_detect"}, 32'(dl_detect_out),       32'd0);
        check({tag, "_valid"},  32'(rpt_if.report_valid), 32'd0);
        check({tag, "_index"},  32'(rpt_if.dl_index),     32'd0);
        check({tag, "_snap"},   32'(rpt_if.dl_snap_vec),  32'd0);
    endtask

    // Wait for the handshake, compare the payload against the queue head.
    task automatic wait_report(input string tag, input int max_cycles);
        exp_t e;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (rpt_if.report_valid && rpt_if.report_ready) begin
                if (sb_q.size() == 0) begin
                    check({tag, "_unexpected_report"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, "_index"}, 32'(rpt_if.dl_index),    32'(e.idx));
                    check({tag, "_snap"},  32'(rpt_if.dl_snap_vec), 32'(e.vec));
                end
                step();
                check({tag, "_valid_drop"}, 32'(rpt_if.report_valid), 32'd0);
                check({tag, "_sticky"},     32'(dl_detect_out),       32'd1);
                done = 1'b1;
            end else begin
                step();
            end
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic clear_pulse(input string tag);
        dl_in_vec = '0;
        clear     = 1'b1;
        step();
        clear     = 1'b0;
        check_all_zero(tag);
    endtask

    initial begin
        reset                = 1'b1;
        clear                = 1'b0;
        dl_in_vec            = '0;
        rpt_if.report_ready  = 1'b0;
        repeat (2) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Persistent block on monitor 0, logger already ready.
        rpt_if.report_ready = 1'b1;
        push_exp(2'd0, 4'b0001);
        hold_vec(4'b0001, CONFIRM_CYCLES - 1);
        check("persist_early_detect", 32'(dl_detect_out), 32'd0);
        check("persist_early_valid",  32'(rpt_if.report_valid), 32'd0);
        step();
        check("persist_detect", 32'(dl_detect_out), 32'd1);
        check("persist_valid",  32'(rpt_if.report_valid), 32'd1);
        wait_report("persist", 4);
        clear_pulse("persist_clear");

        // Transient stall of C-1 edges, then a full episode on monitor 2.
        hold_vec(4'b0100, CONFIRM_CYCLES - 1);
        hold_vec(4'b0000, 1);
        check("transient_detect", 32'(dl_detect_out), 32'd0);
        hold_vec(4'b0000, 3);
        check("transient_valid", 32'(rpt_if.report_valid), 32'd0);
        push_exp(2'd2, 4'b0100);
        hold_vec(4'b0100, CONFIRM_CYCLES - 1);
        check("transient_full_early", 32'(dl_detect_out), 32'd0);
        step();
        check("transient_full_detect", 32'(dl_detect_out), 32'd1);
        wait_report("transient", 4);
        clear_pulse("transient_clear");

        // Shrinking candidate set.
        push_exp(2'd2, 4'b0100);
        hold_vec(4'b0110, 5);
        hold_vec(4'b0100, CONFIRM_CYCLES - 6);
        check("shrink_early", 32'(dl_detect_out), 32'd0);
        step();
        check("shrink_detect", 32'(dl_detect_out), 32'd1);
        check("shrink_snap_now", 32'(rpt_if.dl_snap_vec), 32'h4);
        wait_report("shrink", 4);
        clear_pulse("shrink_clear");

        // Alternating disjoint monitors never confirm.
        for (int k = 0; k < 40; k++) begin
            hold_vec((k % 2 == 0) ? 4'b0001 : 4'b1000, 1);
        end
        check("alternate_detect", 32'(dl_detect_out), 32'd0);
        check("alternate_valid",  32'(rpt_if.report_valid), 32'd0);
        hold_vec(4'b0000, 2);

        // Backpressure: report stays offered and stable, HOLD ignores inputs.
        rpt_if.report_ready = 1'b0;
        push_exp(2'd1, 4'b0010);
        hold_vec(4'b0010, CONFIRM_CYCLES);
        check("bp_valid_rise", 32'(rpt_if.report_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            hold_vec((k % 2 == 0) ? 4'b1000 : 4'b0001, 1);
            check("bp_valid_hold", 32'(rpt_if.report_valid), 32'd1);
            check("bp_index_hold", 32'(rpt_if.dl_index),     32'd1);
        end
        rpt_if.report_ready = 1'b1;
        wait_report("bp", 3);
        hold_vec(4'b1000, 5);
        check("hold_index", 32'(rpt_if.dl_index),    32'd1);
        check("hold_snap",  32'(rpt_if.dl_snap_vec), 32'h2);
        check("hold_valid", 32'(rpt_if.report_valid), 32'd0);

        // Clear in HOLD then re-arm on monitor 3.
        clear_pulse("hold_clear");
        push_exp(2'd3, 4'b1000);
        hold_vec(4'b1000, CONFIRM_CYCLES);
        check("rearm_detect", 32'(dl_detect_out), 32'd1);
        wait_report("rearm", 4);
        clear_pulse("rearm_clear");

        // Clear mid-confirm restarts one edge later.
        hold_vec(4'b0001, 5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("mid_clear_detect", 32'(dl_detect_out), 32'd0);
        push_exp(2'd0, 4'b0001);
        hold_vec(4'b0001, CONFIRM_CYCLES - 1);
        check("mid_clear_early", 32'(dl_detect_out), 32'd0);
        step();
        check("mid_clear_confirm", 32'(dl_detect_out), 32'd1);
        wait_report("mid_clear", 4);
        clear_pulse("mid_clear_done");

        // Reset at cnt=9 aborts the confirmation.
        hold_vec(4'b0001, 9);
        reset = 1'b1;
        step();
        check_all_zero("rst_confirm");
        reset     = 1'b0;
        dl_in_vec = '0;
        repeat (CONFIRM_CYCLES + 4) step();
        check("rst_confirm_after", 32'(dl_detect_out), 32'd0);

        // Reset during REPORT drops the report unaccepted.
        rpt_if.report_ready = 1'b0;
        hold_vec(4'b0100, CONFIRM_CYCLES);
        check("rst_report_valid", 32'(rpt_if.report_valid), 32'd1);
        reset = 1'b1;
        step();
        check_all_zero("rst_report");
        reset               = 1'b0;
        dl_in_vec           = '0;
        rpt_if.report_ready = 1'b1;
        repeat (3) step();
        check("rst_report_after_valid",  32'(rpt_if.report_valid), 32'd0);
        check("rst_report_after_detect", 32'(dl_detect_out),       32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Run-time bound in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
